// File: rtl/glitch_pkg.sv
// Shared types and helpers for the glitch sweep controller.
package glitch_pkg;

    // Default width of all delay/width/holdoff/count values.
    localparam int unsigned CNT_W_DEFAULT = 32;

    // Sequencer states.
    typedef logic [2:0] state_t;
    localparam state_t StIdle    = 3'd0;
    localparam state_t StArm     = 3'd1;
    localparam state_t StDelay   = 3'd2;
    localparam state_t StPulse   = 3'd3;
    localparam state_t StHoldoff = 3'd4;

    // PLL clock frequency used for host-side ns -> cycle conversion.
    localparam int unsigned PLL_MHZ = 204;

    // Convert a delay in ns to PLL cycles, rounding up so a request is never shortened.
    function automatic logic [CNT_W_DEFAULT-1:0] ns_to_cycles(input logic [CNT_W_DEFAULT-1:0] ns);
        logic [63:0] prod;
        prod = 64'(ns) * 64'(PLL_MHZ) + 64'd999;
        return CNT_W_DEFAULT'(prod / 64'd1000);
    endfunction

endpackage

// File: rtl/trig_sync.sv
// Trigger synchronizer: SYNC_STAGES flops into the clk domain plus a rising-edge detect flop.
module trig_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic trigger_i,
    output logic trig_rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Shift the raw trigger through the synchronizer and remember the last synchronized level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], trigger_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign trig_rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/glitch_sweep_ctrl.sv
// Glitch sweep sequencer: arm on trigger, wait delay, pulse glitch, hold off, advance sweep point.
// Define GLITCH_SWEEP_WIDTH_EN to enable the second (glitch width) sweep dimension.
module glitch_sweep_ctrl
    import glitch_pkg::*;
#(
    parameter int unsigned CNT_W       = CNT_W_DEFAULT,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             trigger_i,
    input  logic [CNT_W-1:0] cfg_delay_start_i,
    input  logic [CNT_W-1:0] cfg_delay_step_i,
    input  logic [CNT_W-1:0] cfg_delay_count_i,
    input  logic [CNT_W-1:0] cfg_width_start_i,
    input  logic [CNT_W-1:0] cfg_width_count_i,
    input  logic [CNT_W-1:0] cfg_holdoff_i,
    output logic             glitch_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             attempt_stb_o,
    output logic [CNT_W-1:0] cur_delay_o,
    output logic [CNT_W-1:0] cur_width_o,
    output logic             delay_indicator_o,
    output logic             done_indicator_o
);

    localparam logic [CNT_W-1:0] One = CNT_W'(1);

    logic trig_rise;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] dstart_q, dstart_d;
    logic [CNT_W-1:0] dstep_q, dstep_d;
    logic [CNT_W-1:0] dcount_q, dcount_d;
    logic [CNT_W-1:0] holdoff_q, holdoff_d;
    logic [CNT_W-1:0] didx_q, didx_d;
    logic [CNT_W-1:0] cur_delay_q, cur_delay_d;
    logic [CNT_W-1:0] cur_width_q, cur_width_d;
    logic             glitch_q, glitch_d;
    logic             stb_q, stb_d;
    logic             done_q, done_d;
    logic             done_ind_q, done_ind_d;
    logic             finish;
`ifdef GLITCH_SWEEP_WIDTH_EN
    logic [CNT_W-1:0] wcount_q, wcount_d;
    logic [CNT_W-1:0] widx_q, widx_d;
`else
    logic             unused_width_count;
    assign unused_width_count = ^cfg_width_count_i;
`endif

    trig_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_trig_sync (
        .clk         (clk),
        .rst_n       (rst_n),
        .trigger_i   (trigger_i),
        .trig_rise_o (trig_rise)
    );

    // Next-state logic: abort overrides the whole sequencer; one shared down-counter per phase.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dstart_d    = dstart_q;
        dstep_d     = dstep_q;
        dcount_d    = dcount_q;
        holdoff_d   = holdoff_q;
        didx_d      = didx_q;
        cur_delay_d = cur_delay_q;
        cur_width_d = cur_width_q;
        glitch_d    = glitch_q;
        stb_d       = 1'b0;
        done_d      = 1'b0;
        done_ind_d  = done_ind_q;
        finish      = 1'b0;
`ifdef GLITCH_SWEEP_WIDTH_EN
        wcount_d    = wcount_q;
        widx_d      = widx_q;
`endif
        if (abort_i) begin
            state_d  = StIdle;
            glitch_d = 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        dstart_d    = cfg_delay_start_i;
                        dstep_d     = cfg_delay_step_i;
                        dcount_d    = (cfg_delay_count_i == '0) ? One : cfg_delay_count_i;
                        holdoff_d   = cfg_holdoff_i;
                        cur_delay_d = cfg_delay_start_i;
                        cur_width_d = (cfg_width_start_i == '0) ? One : cfg_width_start_i;
                        didx_d      = '0;
`ifdef GLITCH_SWEEP_WIDTH_EN
                        wcount_d    = (cfg_width_count_i == '0) ? One : cfg_width_count_i;
                        widx_d      = '0;
`endif
                        done_ind_d  = 1'b0;
                        state_d     = StArm;
                    end
                end
                StArm: begin
                    if (trig_rise) begin
                        cnt_d   = cur_delay_q;
                        state_d = StDelay;
                    end
                end
                StDelay: begin
                    // DELAY occupies cur_delay+1 cycles; glitch flop rises on the exit edge.
                    if (cnt_q == '0) begin
                        cnt_d    = cur_width_q - One;
                        glitch_d = 1'b1;
                        state_d  = StPulse;
                    end else begin
                        cnt_d = cnt_q - One;
                    end
                end
                StPulse: begin
                    if (cnt_q == '0) begin
                        glitch_d = 1'b0;
                        stb_d    = 1'b1;
                        cnt_d    = (holdoff_q == '0) ? '0 : holdoff_q - One;
                        state_d  = StHoldoff;
                    end else begin
                        cnt_d = cnt_q - One;
                    end
                end
                StHoldoff: begin
                    if (cnt_q == '0) begin
                        if (didx_q + One == dcount_q) begin
                            didx_d      = '0;
                            cur_delay_d = dstart_q;
`ifdef GLITCH_SWEEP_WIDTH_EN
                            if (widx_q + One == wcount_q) begin
                                finish = 1'b1;
                            end else begin
                                widx_d      = widx_q + One;
                                cur_width_d = cur_width_q + One;
                            end
`else
                            finish      = 1'b1;
`endif
                        end else begin
                            didx_d      = didx_q + One;
                            cur_delay_d = cur_delay_q + dstep_q;
                        end
                        if (finish) begin
                            done_d     = 1'b1;
                            done_ind_d = 1'b1;
                            state_d    = StIdle;
                        end else begin
                            state_d = StArm;
                        end
                    end else begin
                        cnt_d = cnt_q - One;
                    end
                end
                default: begin
                    glitch_d = 1'b0;
                    state_d  = StIdle;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            dstart_q    <= '0;
            dstep_q     <= '0;
            dcount_q    <= '0;
            holdoff_q   <= '0;
            didx_q      <= '0;
            cur_delay_q <= '0;
            cur_width_q <= '0;
            glitch_q    <= 1'b0;
            stb_q       <= 1'b0;
            done_q      <= 1'b0;
            done_ind_q  <= 1'b0;
`ifdef GLITCH_SWEEP_WIDTH_EN
            wcount_q    <= '0;
            widx_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dstart_q    <= dstart_d;
            dstep_q     <= dstep_d;
            dcount_q    <= dcount_d;
            holdoff_q   <= holdoff_d;
            didx_q      <= didx_d;
            cur_delay_q <= cur_delay_d;
            cur_width_q <= cur_width_d;
            glitch_q    <= glitch_d;
            stb_q       <= stb_d;
            done_q      <= done_d;
            done_ind_q  <= done_ind_d;
`ifdef GLITCH_SWEEP_WIDTH_EN
            wcount_q    <= wcount_d;
            widx_q      <= widx_d;
`endif
        end
    end

    assign glitch_o          = glitch_q;
    assign busy_o            = (state_q != StIdle);
    assign done_o            = done_q;
    assign attempt_stb_o     = stb_q;
    assign cur_delay_o       = cur_delay_q;
    assign cur_width_o       = cur_width_q;
    assign delay_indicator_o = (state_q == StDelay);
    assign done_indicator_o  = done_ind_q;

endmodule

// File: tb/tb_glitch_sweep_ctrl.sv
// Directed bench for glitch_sweep_ctrl (SYNC_STAGES=2, CNT_W=32).
module tb_glitch_sweep_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic        trigger;
    logic [31:0] cfg_delay_start;
    logic [31:0] cfg_delay_step;
    logic [31:0] cfg_delay_count;
    logic [31:0] cfg_width_start;
    logic [31:0] cfg_width_count;
    logic [31:0] cfg_holdoff;
    logic        glitch_o;
    logic        busy_o;
    logic        done_o;
    logic        attempt_stb_o;
    logic [31:0] cur_delay_o;
    logic [31:0] cur_width_o;
    logic        delay_indicator_o;
    logic        done_indicator_o;

    int checks = 0;
    int errors = 0;
    int stb_cnt = 0;
    int done_cnt = 0;
    int glitch_cnt = 0;

    glitch_sweep_ctrl #(
        .CNT_W       (32),
        .SYNC_STAGES (2)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start_i           (start),
        .abort_i           (abort),
        .trigger_i         (trigger),
        .cfg_delay_start_i (cfg_delay_start),
        .cfg_delay_step_i  (cfg_delay_step),
        .cfg_delay_count_i (cfg_delay_count),
        .cfg_width_start_i (cfg_width_start),
        .cfg_width_count_i (cfg_width_count),
        .cfg_holdoff_i     (cfg_holdoff),
        .glitch_o          (glitch_o),
        .busy_o            (busy_o),
        .done_o            (done_o),
        .attempt_stb_o     (attempt_stb_o),
        .cur_delay_o       (cur_delay_o),
        .cur_width_o       (cur_width_o),
        .delay_indicator_o (delay_indicator_o),
        .done_indicator_o  (done_indicator_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event counters, sampled at the rising edge (values from the previous cycle).
    always @(posedge clk) begin
        if (attempt_stb_o === 1'b1) stb_cnt <= stb_cnt + 1;
        if (done_o === 1'b1) done_cnt <= done_cnt + 1;
        if (glitch_o === 1'b1) glitch_cnt <= glitch_cnt + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic do_start(input logic [31:0] ds, input logic [31:0] st, input logic [31:0] dc,
                            input logic [31:0] ws, input logic [31:0] wc, input logic [31:0] ho);
        cfg_delay_start = ds;
        cfg_delay_step  = st;
        cfg_delay_count = dc;
        cfg_width_start = ws;
        cfg_width_count = wc;
        cfg_holdoff     = ho;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Raise trigger at a negedge, measure cycles to glitch rise and glitch width,
    // then check the strobe and the reported sweep point. Returns on the strobe cycle.
    task automatic run_attempt(input string tag, input int exp_lat, input int exp_w,
                               input logic [31:0] exp_d, input logic [31:0] exp_wd);
        int lat;
        int w;
        trigger = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (glitch_o !== 1'b1 && lat < 300);
        trigger = 1'b0;
        chk({tag, " latency"}, lat, exp_lat);
        w = 0;
        while (glitch_o === 1'b1 && w < 300) begin
            @(negedge clk);
            w++;
        end
        chk({tag, " width"}, w, exp_w);
        chk({tag, " attempt_stb"}, attempt_stb_o, 1);
        chk({tag, " cur_delay"}, cur_delay_o, exp_d);
        chk({tag, " cur_width"}, cur_width_o, exp_wd);
    endtask

    task automatic wait_done(input string tag, input int budget, input int exp_n);
        int n;
        n = 0;
        while (done_o !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " done delay"}, n, exp_n);
        chk({tag, " busy low at done"}, busy_o, 0);
        chk({tag, " done_indicator"}, done_indicator_o, 1);
    endtask

    initial begin
        int s0;
        int d0;
        int g0;
        int lat;
        rst_n = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        trigger = 1'b0;
        cfg_delay_start = 32'd0;
        cfg_delay_step = 32'd0;
        cfg_delay_count = 32'd0;
        cfg_width_start = 32'd0;
        cfg_width_count = 32'd0;
        cfg_holdoff = 32'd0;
        #1 rst_n = 1'b0;
        tick(3);

        // Reset state
        chk("rst glitch", glitch_o, 0);
        chk("rst busy", busy_o, 0);
        chk("rst done", done_o, 0);
        chk("rst stb", attempt_stb_o, 0);
        chk("rst cur_delay", cur_delay_o, 0);
        chk("rst cur_width", cur_width_o, 0);
        chk("rst delay_ind", delay_indicator_o, 0);
        chk("rst done_ind", done_indicator_o, 0);
        rst_n = 1'b1;
        tick(2);

        // Single point: delay 10, width 3, holdoff 0
        do_start(32'd10, 32'd0, 32'd1, 32'd3, 32'd1, 32'd0);
        chk("t1 busy", busy_o, 1);
        chk("t1 cur_delay", cur_delay_o, 10);
        chk("t1 cur_width", cur_width_o, 3);
        tick(3);
        run_attempt("t1", 14, 3, 32'd10, 32'd3);
        chk("t1 done not with stb", done_o, 0);
        tick(1);
        chk("t1 done", done_o, 1);
        chk("t1 busy low", busy_o, 0);
        chk("t1 done_ind", done_indicator_o, 1);
        tick(1);
        chk("t1 done one cycle", done_o, 0);
        chk("t1 done_ind held", done_indicator_o, 1);

        // Three-point delay sweep; a second start while busy must be ignored
        s0 = stb_cnt;
        d0 = done_cnt;
        do_start(32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd3);
        chk("t2 done_ind cleared", done_indicator_o, 0);
        cfg_delay_start = 32'd99;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(2);
        run_attempt("t2a", 9, 2, 32'd5, 32'd2);
        tick(8);
        run_attempt("t2b", 13, 2, 32'd9, 32'd2);
        tick(8);
        run_attempt("t2c", 17, 2, 32'd13, 32'd2);
        wait_done("t2", 20, 3);
        g0 = glitch_cnt;
        trigger = 1'b1;
        tick(30);
        trigger = 1'b0;
        tick(2);
        chk("t2 4th trigger no glitch", glitch_cnt - g0, 0);
        chk("t2 strobes", stb_cnt - s0, 3);
        chk("t2 done pulses", done_cnt - d0, 1);

        // Width dimension (or its absence in the default build)
        do_start(32'd3, 32'd2, 32'd2, 32'd1, 32'd2, 32'd0);
        tick(3);
        run_attempt("t3a", 7, 1, 32'd3, 32'd1);
        tick(4);
        run_attempt("t3b", 9, 1, 32'd5, 32'd1);
`ifdef GLITCH_SWEEP_WIDTH_EN
        tick(4);
        run_attempt("t3c", 7, 2, 32'd3, 32'd2);
        tick(4);
        run_attempt("t3d", 9, 2, 32'd5, 32'd2);
`endif
        wait_done("t3", 10, 1);
        tick(2);

        // Trigger already high through start, then zero delay and zero width
        trigger = 1'b1;
        tick(5);
        g0 = glitch_cnt;
        do_start(32'd0, 32'd0, 32'd1, 32'd0, 32'd1, 32'd0);
        chk("t4 width clamp", cur_width_o, 1);
        tick(20);
        chk("t4 held trigger no glitch", glitch_cnt - g0, 0);
        chk("t4 still armed", busy_o, 1);
        trigger = 1'b0;
        tick(4);
        run_attempt("t4", 4, 1, 32'd0, 32'd1);
        wait_done("t4", 10, 1);
        tick(2);

        // Trigger pulse during a long holdoff is dropped
        do_start(32'd2, 32'd0, 32'd2, 32'd1, 32'd1, 32'd50);
        tick(3);
        run_attempt("t5a", 6, 1, 32'd2, 32'd1);
        tick(5);
        g0 = glitch_cnt;
        s0 = stb_cnt;
        trigger = 1'b1;
        tick(3);
        trigger = 1'b0;
        tick(60);
        chk("t5 holdoff trigger no glitch", glitch_cnt - g0, 0);
        chk("t5 holdoff trigger no stb", stb_cnt - s0, 0);
        chk("t5 armed after holdoff", busy_o, 1);
        run_attempt("t5b", 6, 1, 32'd2, 32'd1);
        wait_done("t5", 60, 50);
        tick(2);

        // Abort in the middle of a 20-cycle pulse
        do_start(32'd1, 32'd0, 32'd1, 32'd20, 32'd1, 32'd0);
        chk("t6 done_ind cleared", done_indicator_o, 0);
        tick(3);
        s0 = stb_cnt;
        d0 = done_cnt;
        trigger = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (glitch_o !== 1'b1 && lat < 100);
        trigger = 1'b0;
        chk("t6 latency", lat, 5);
        tick(4);
        chk("t6 glitch before abort", glitch_o, 1);
        abort = 1'b1;
        tick(1);
        chk("t6 glitch after abort", glitch_o, 0);
        chk("t6 busy after abort", busy_o, 0);
        chk("t6 stb after abort", attempt_stb_o, 0);
        chk("t6 done after abort", done_o, 0);
        abort = 1'b0;
        tick(25);
        chk("t6 no strobe", stb_cnt - s0, 0);
        chk("t6 no done", done_cnt - d0, 0);
        chk("t6 done_ind", done_indicator_o, 0);

        // Asynchronous reset while in DELAY
        do_start(32'd30, 32'd0, 32'd1, 32'd2, 32'd1, 32'd0);
        tick(3);
        trigger = 1'b1;
        tick(8);
        trigger = 1'b0;
        chk("t7 in delay", delay_indicator_o, 1);
        chk("t7 cur_delay before reset", cur_delay_o, 30);
        rst_n = 1'b0;
        #1;
        chk("t7 rst busy", busy_o, 0);
        chk("t7 rst delay_ind", delay_indicator_o, 0);
        chk("t7 rst glitch", glitch_o, 0);
        chk("t7 rst cur_delay", cur_delay_o, 0);
        chk("t7 rst cur_width", cur_width_o, 0);
        chk("t7 rst stb", attempt_stb_o, 0);
        g0 = glitch_cnt;
        tick(2);
        rst_n = 1'b1;
        tick(40);
        chk("t7 no glitch after reset", glitch_cnt - g0, 0);
        chk("t7 idle after reset", busy_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/glitch_sweep_ctrl.md
# glitch_sweep_ctrl

Sequencer that drives a parameter sweep of glitch attempts on the PLL clock domain. Each run arms on the external trigger, waits a programmed delay, drives `glitch` high for a programmed width, then holds off and advances the sweep point. It sits between the host-facing configuration registers and the glitch output pin. It replaces fixed delay/width constants with a runtime-programmable 1-D or 2-D sweep.

## Interface
- `CNT_W`, 32: width of all delay/width/holdoff/count values.
- `SYNC_STAGES`, 2: trigger synchronizer depth (≥2).

Ports:
- `clk`  in  1  PLL clock; all logic on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse; samples all `cfg_*` and begins a sweep (ignored unless IDLE).
- `abort`  in  1  level; forces IDLE; has priority over everything except reset.
- `trigger`  in  1  asynchronous target trigger.
- `cfg_delay_start`  in  CNT_W  first delay, in cycles.
- `cfg_delay_step`  in  CNT_W  delay increment per point.
- `cfg_delay_count`  in  CNT_W  number of delay points (0 treated as 1).
- `cfg_width_start`  in  CNT_W  first glitch width, in cycles (0 treated as 1).
- `cfg_width_count`  in  CNT_W  number of width points (0 treated as 1).
- `cfg_holdoff`  in  CNT_W  idle cycles after each pulse.
- `glitch`  out  1  glitch drive, registered.
- `busy`  out  1  high from the cycle after `start` until return to IDLE.
- `done`  out  1  one-cycle pulse when the sweep completes (not on abort).
- `attempt_stb`  out  1  one-cycle pulse on the cycle `glitch` falls.
- `cur_delay`, `cur_width`  out  CNT_W  current sweep point; valid while `attempt_stb` is high.
- `delay_indicator`  out  1  high in DELAY.
- `done_indicator`  out  1  set by `done`; cleared by `start`.

## Operation
- States: IDLE, ARM, DELAY, PULSE, HOLDOFF.
- Reset: all outputs are 0. State is IDLE. Counters and latched config are 0.
- IDLE + `start`:
  - latch `cfg_*`;
  - set `cur_delay`=delay_start, `cur_width`=max(width_start,1);
  - clear indices;
  - go to ARM.
- ARM: wait for a rising edge on the synchronized trigger (level high alone is insufficient). On the edge, load the delay counter and go to DELAY.
- DELAY: count `cur_delay` cycles, then go to PULSE. `cur_delay`=0 enters PULSE on the next cycle.
- PULSE: `glitch`=1 for exactly `cur_width` cycles. On exit, pulse `attempt_stb` and go to HOLDOFF.
- HOLDOFF: count `cfg_holdoff` cycles (0 means one cycle), then advance the sweep point:
  - Delay index increments. `cur_delay` += step, wrapping modulo 2^CNT_W.
  - When the delay index reaches delay_count, it resets to 0, `cur_delay` reloads, the width index increments and `cur_width` += 1.
  - When the width index reaches width_count: pulse `done`, go to IDLE.
  - Otherwise go to ARM.
- `abort`: state goes to IDLE and `glitch`=0 at the next edge. No `done` pulse, no `attempt_stb`.
- Trigger edges outside ARM are ignored; there is no queuing.
- `start` while busy is ignored.

## Timing
- Trigger path: `SYNC_STAGES` flops plus one edge-detect flop.
- Latency from trigger pin rise to `glitch` rise is SYNC_STAGES+1+cur_delay+1 cycles (±1 for async sampling).
- `glitch` high time is exactly `cur_width` cycles, glitch-free, driven from a single flop.
- `attempt_stb` is coincident with the first low cycle of `glitch`.
- `done` is coincident with the IDLE entry edge. `busy` falls in the same cycle.
- Total attempts per sweep = max(delay_count,1) × max(width_count,1).

## Configuration
- `GLITCH_SWEEP_WIDTH_EN` defined: 2-D sweep as above.
- Not defined: `cfg_width_count` is ignored (treated as 1), `cur_width` stays fixed at max(width_start,1), and the width-index logic is not compiled. `done` follows the last delay point.

## Structure
- Package `glitch_pkg`: state enum (`logic [2:0]`), `CNT_W` default, and the delay-count helper for ns→cycle conversion at 204 MHz.
- One sub-module: `trig_sync` (N-stage synchronizer plus rising-edge detect, output `trig_rise`).

## Test plan
- delay_start=10, step=0, count=1, width=3, holdoff=0; one trigger → `glitch` rises 10+SYNC_STAGES+2 cycles after the trigger, high for 3 cycles, then one `attempt_stb` and `done`.
- delay_start=5, step=4, count=3; three triggers → `cur_delay` at strobes is 5, 9, 13; `done` after the third attempt; a 4th trigger produces no glitch.
- With `GLITCH_SWEEP_WIDTH_EN`: delay_count=2, width_start=1, width_count=2 → (delay,width) sequence (d0,1),(d1,1),(d0,2),(d1,2); glitch widths 1,1,2,2.
- width_start=0, delay_start=0 → glitch one cycle wide, starting one cycle after DELAY entry.
- Assert `abort` mid-PULSE (width=20, cycle 5) → `glitch`=0 on the next edge; state IDLE; no `attempt_stb`, no `done`; `busy` low.
- Trigger held high through `start`, or pulsed during HOLDOFF (holdoff=50) → no attempt until a fresh rising edge in ARM.
- Assert `rst_n` low mid-DELAY → all outputs 0 immediately, state IDLE.
